// File: rtl/soundgen.sv
// soundgen: three-stage voice/aux mixer that accumulates stereo contributions
// over a 48 kHz frame and presents saturated 18-bit samples on each frame tick.
module soundgen #(
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [9:0]  wavetable_r,
  input  logic               wavetable_r_valid,
  input  logic signed [9:0]  wavetable_l,
  input  logic               wavetable_l_valid,
  input  logic signed [15:0] sound,
  input  logic               sound_valid,
  input  logic        [17:0] volume_adsr,
  input  logic        [17:0] velocity,
  input  logic               tick48k,
  output logic signed [17:0] sound_r,
  output logic signed [17:0] sound_l
);

  localparam logic signed [ACC_W+1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] S18_MAX = {{(ACC_W-17){1'b0}}, {17{1'b1}}};
  localparam logic signed [ACC_W-1:0] S18_MIN = {{(ACC_W-17){1'b1}}, {17{1'b0}}};

  // Clamp an accumulator-width value to the 18-bit output range.
  function automatic logic signed [17:0] sat18(input logic signed [ACC_W-1:0] v);
    if (v > S18_MAX)      sat18 = 18'sh1FFFF;
    else if (v < S18_MIN) sat18 = 18'sh20000;
    else                  sat18 = v[17:0];
  endfunction

  // Clamp a widened sum back into the accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] v);
    if (v > ACC_MAX)      sat_acc = ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) sat_acc = ACC_MIN[ACC_W-1:0];
    else                  sat_acc = v[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W+1:0] ext18(input logic signed [17:0] v);
    ext18 = {{(ACC_W-16){v[17]}}, v};
  endfunction

  function automatic logic signed [ACC_W+1:0] ext_acc(input logic signed [ACC_W-1:0] v);
    ext_acc = {{2{v[ACC_W-1]}}, v};
  endfunction

  // Stage 1 registers
  logic        [16:0] gain_p0_q, gain_p0_d;
  logic signed [9:0]  smp_r_p0_q, smp_r_p0_d, smp_l_p0_q, smp_l_p0_d;
  logic               vld_r_p0_q, vld_r_p0_d, vld_l_p0_q, vld_l_p0_d;
  logic signed [17:0] aux_p0_q, aux_p0_d;
  logic               vld_a_p0_q, vld_a_p0_d;
  // Stage 2 registers
  logic signed [17:0] con_r_p1_q, con_r_p1_d, con_l_p1_q, con_l_p1_d;
  logic               vld_r_p1_q, vld_r_p1_d, vld_l_p1_q, vld_l_p1_d;
  logic signed [17:0] aux_p1_q, aux_p1_d;
  logic               vld_a_p1_q, vld_a_p1_d;
  // Stage 3 accumulators and frame outputs
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d, acc_l_q, acc_l_d;
  logic signed [17:0]      sound_r_q, sound_r_d, sound_l_q, sound_l_d;

  logic        [33:0] gain_prod;
  logic signed [27:0] smp_r_x, smp_l_x, gain_x, prod_r, prod_l;
  logic signed [17:0] add_r, add_l, add_a;
  logic signed [ACC_W-1:0] base_r, base_l;
  logic signed [ACC_W+1:0] sum_r, sum_l;

  // Stage 1: combine envelope and velocity into one gain, capture samples
  always_comb begin
    gain_prod  = {17'b0, volume_adsr[16:0]} * {17'b0, velocity[16:0]};
    gain_p0_d  = gain_prod[33:17];
    smp_r_p0_d = wavetable_r;
    smp_l_p0_d = wavetable_l;
    vld_r_p0_d = wavetable_r_valid;
    vld_l_p0_d = wavetable_l_valid;
    aux_p0_d   = {sound, 2'b00};
    vld_a_p0_d = sound_valid;
  end

  // Stage 2: scale each sample by the shared gain, floor-truncating the result
  always_comb begin
    smp_r_x    = {{18{smp_r_p0_q[9]}}, smp_r_p0_q};
    smp_l_x    = {{18{smp_l_p0_q[9]}}, smp_l_p0_q};
    gain_x     = {11'b0, gain_p0_q};
    prod_r     = smp_r_x * gain_x;
    prod_l     = smp_l_x * gain_x;
    con_r_p1_d = prod_r[26:9];
    con_l_p1_d = prod_l[26:9];
    vld_r_p1_d = vld_r_p0_q;
    vld_l_p1_d = vld_l_p0_q;
    aux_p1_d   = aux_p0_q;
    vld_a_p1_d = vld_a_p0_q;
  end

  // Stage 3: accumulate voice and aux; a tick publishes the frame and restarts it
  always_comb begin
    add_r     = vld_r_p1_q ? con_r_p1_q : 18'sd0;
    add_l     = vld_l_p1_q ? con_l_p1_q : 18'sd0;
    add_a     = vld_a_p1_q ? aux_p1_q   : 18'sd0;
    base_r    = tick48k ? '0 : acc_r_q;
    base_l    = tick48k ? '0 : acc_l_q;
    sum_r     = ext_acc(base_r) + ext18(add_r) + ext18(add_a);
    sum_l     = ext_acc(base_l) + ext18(add_l) + ext18(add_a);
    acc_r_d   = sat_acc(sum_r);
    acc_l_d   = sat_acc(sum_l);
    sound_r_d = tick48k ? sat18(acc_r_q) : sound_r_q;
    sound_l_d = tick48k ? sat18(acc_l_q) : sound_l_q;
  end

  // State registers; reset clears everything so in-flight work is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gain_p0_q  <= '0;
      smp_r_p0_q <= '0;
      smp_l_p0_q <= '0;
      vld_r_p0_q <= 1'b0;
      vld_l_p0_q <= 1'b0;
      aux_p0_q   <= '0;
      vld_a_p0_q <= 1'b0;
      con_r_p1_q <= '0;
      con_l_p1_q <= '0;
      vld_r_p1_q <= 1'b0;
      vld_l_p1_q <= 1'b0;
      aux_p1_q   <= '0;
      vld_a_p1_q <= 1'b0;
      acc_r_q    <= '0;
      acc_l_q    <= '0;
      sound_r_q  <= '0;
      sound_l_q  <= '0;
    end else begin
      gain_p0_q  <= gain_p0_d;
      smp_r_p0_q <= smp_r_p0_d;
      smp_l_p0_q <= smp_l_p0_d;
      vld_r_p0_q <= vld_r_p0_d;
      vld_l_p0_q <= vld_l_p0_d;
      aux_p0_q   <= aux_p0_d;
      vld_a_p0_q <= vld_a_p0_d;
      con_r_p1_q <= con_r_p1_d;
      con_l_p1_q <= con_l_p1_d;
      vld_r_p1_q <= vld_r_p1_d;
      vld_l_p1_q <= vld_l_p1_d;
      aux_p1_q   <= aux_p1_d;
      vld_a_p1_q <= vld_a_p1_d;
      acc_r_q    <= acc_r_d;
      acc_l_q    <= acc_l_d;
      sound_r_q  <= sound_r_d;
      sound_l_q  <= sound_l_d;
    end
  end

  assign sound_r = sound_r_q;
  assign sound_l = sound_l_q;

  // Bits deliberately dropped by the gain format and the fixed-point scaling
  logic unused_bits;
  assign unused_bits = ^{volume_adsr[17], velocity[17], gain_prod[16:0],
                         prod_r[27], prod_r[8:0], prod_l[27], prod_l[8:0]};

endmodule

// File: tb/tb_soundgen.sv
// tb_soundgen: directed vector table plus hand sequences for reset,
// frame-boundary, hold and mid-frame reset behaviour of soundgen.
module tb_soundgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [9:0]  wavetable_r, wavetable_l;
  logic               wavetable_r_valid, wavetable_l_valid;
  logic signed [15:0] sound;
  logic               sound_valid;
  logic        [17:0] volume_adsr, velocity;
  logic               tick48k;
  logic signed [17:0] sound_r, sound_l;

  soundgen #(.ACC_W(24)) dut (
    .clk               (clk),
    .rst               (rst),
    .wavetable_r       (wavetable_r),
    .wavetable_r_valid (wavetable_r_valid),
    .wavetable_l       (wavetable_l),
    .wavetable_l_valid (wavetable_l_valid),
    .sound             (sound),
    .sound_valid       (sound_valid),
    .volume_adsr       (volume_adsr),
    .velocity          (velocity),
    .tick48k           (tick48k),
    .sound_r           (sound_r),
    .sound_l           (sound_l)
  );

  localparam logic [17:0] FULL = 18'h1FFFF;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [9:0]  wr;
    logic               wrv;
    logic signed [9:0]  wl;
    logic               wlv;
    logic signed [15:0] snd;
    logic               sndv;
    logic        [17:0] vol;
    logic        [17:0] vel;
    int                 reps;
    logic signed [17:0] er;
    logic signed [17:0] el;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic signed [9:0] wr, input logic wrv,
                              input logic signed [9:0] wl, input logic wlv,
                              input logic signed [15:0] snd, input logic sndv,
                              input logic [17:0] vol, input logic [17:0] vel,
                              input int reps,
                              input logic signed [17:0] er, input logic signed [17:0] el);
    vec_t v;
    v.wr = wr; v.wrv = wrv; v.wl = wl; v.wlv = wlv;
    v.snd = snd; v.sndv = sndv; v.vol = vol; v.vel = vel;
    v.reps = reps; v.er = er; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [17:0] act,
                     input logic signed [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_in();
    wavetable_r = '0; wavetable_r_valid = 1'b0;
    wavetable_l = '0; wavetable_l_valid = 1'b0;
    sound = '0; sound_valid = 1'b0;
    volume_adsr = '0; velocity = '0;
    tick48k = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) @(negedge clk);
  endtask

  // One tick cycle; outputs are sampled at the following falling edge
  task automatic do_tick();
    clear_in();
    tick48k = 1'b1;
    @(negedge clk);
    tick48k = 1'b0;
  endtask

  task automatic strobe_r(input logic signed [9:0] s);
    clear_in();
    wavetable_r = s; wavetable_r_valid = 1'b1;
    volume_adsr = FULL; velocity = FULL;
    @(negedge clk);
    clear_in();
  endtask

  task automatic rand_cycle();
    wavetable_r = 10'($urandom); wavetable_r_valid = 1'($urandom);
    wavetable_l = 10'($urandom); wavetable_l_valid = 1'($urandom);
    sound = 16'($urandom); sound_valid = 1'($urandom);
    volume_adsr = 18'($urandom); velocity = 18'($urandom);
    tick48k = 1'($urandom);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    clear_in();

    vecs[0]  = mk(10'sd256,  1, 10'sd0,    0, 16'sd0,   0, FULL, FULL, 1, 18'sd65535,   18'sd0);
    vecs[1]  = mk(10'sd0,    0, -10'sd512, 1, 16'sd0,   0, FULL, FULL, 1, 18'sd0,      -18'sd131070);
    vecs[2]  = mk(10'sd0,    0, 10'sd0,    1, 16'sd0,   0, FULL, FULL, 1, 18'sd0,       18'sd0);
    vecs[3]  = mk(10'sd256,  1, 10'sd0,    0, 16'sd0,   0, 18'h0, FULL, 1, 18'sd0,      18'sd0);
    vecs[4]  = mk(10'sd511,  1, 10'sd0,    0, 16'sd0,   0, FULL, FULL, 2, 18'sd131071,  18'sd0);
    vecs[5]  = mk(-10'sd512, 1, 10'sd0,    0, 16'sd0,   0, FULL, FULL, 2, -18'sd131072, 18'sd0);
    vecs[6]  = mk(10'sd256,  1, 10'sd0,    0, 16'h4000, 1, FULL, FULL, 1, 18'sd131071,  18'sd65536);
    vecs[7]  = mk(10'sd100,  1, -10'sd100, 1, 16'sd0,   0, FULL, FULL, 1, 18'sd25599,  -18'sd25600);
    vecs[8]  = mk(10'sd256,  1, 10'sd0,    0, 16'sd0,   0, 18'h10000, FULL, 1, 18'sd32767, 18'sd0);
    vecs[9]  = mk(10'sd256,  1, 10'sd0,    0, -16'sd4,  1, 18'h3FFFF, 18'h3FFFF, 1, 18'sd65519, -18'sd16);
    vecs[10] = mk(10'sd0,    0, -10'sd1,   1, 16'sd0,   0, FULL, FULL, 2, 18'sd0,      -18'sd512);

    // Held in reset with random activity: outputs stay zero
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) rand_cycle();
    chk("rst_hold_r", sound_r, 18'sd0);
    chk("rst_hold_l", sound_l, 18'sd0);
    clear_in();
    rst = 1'b1;
    idle(4);
    do_tick();
    chk("rst_first_tick_r", sound_r, 18'sd0);
    chk("rst_first_tick_l", sound_l, 18'sd0);

    // Table-driven vectors: strobe(s), settle, tick, compare
    for (int i = 0; i < 11; i++) begin
      clear_in();
      wavetable_r = vecs[i].wr; wavetable_r_valid = vecs[i].wrv;
      wavetable_l = vecs[i].wl; wavetable_l_valid = vecs[i].wlv;
      sound = vecs[i].snd; sound_valid = vecs[i].sndv;
      volume_adsr = vecs[i].vol; velocity = vecs[i].vel;
      repeat (vecs[i].reps) @(negedge clk);
      idle(3);
      do_tick();
      chk($sformatf("vec%0d_r", i), sound_r, vecs[i].er);
      chk($sformatf("vec%0d_l", i), sound_l, vecs[i].el);
    end

    // Strobe two cycles before the tick lands in the next frame
    strobe_r(10'sd256);
    idle(1);
    do_tick();
    chk("bnd_excluded_r", sound_r, 18'sd0);
    idle(3);
    do_tick();
    chk("bnd_next_frame_r", sound_r, 18'sd65535);

    // Output holds between ticks while a new frame accumulates
    strobe_r(10'sd256);
    idle(4);
    chk("hold_r", sound_r, 18'sd65535);
    do_tick();
    chk("hold_new_frame_r", sound_r, 18'sd65535);
    do_tick();
    chk("bnd_empty_r", sound_r, 18'sd0);
    chk("bnd_empty_l", sound_l, 18'sd0);

    // Asynchronous reset clears a nonzero output before any clock edge
    strobe_r(10'sd256);
    idle(3);
    do_tick();
    chk("pre_async_r", sound_r, 18'sd65535);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_r", sound_r, 18'sd0);
    chk("async_rst_l", sound_l, 18'sd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Mid-frame reset drops in-flight and accumulated work
    strobe_r(10'sd256);
    strobe_r(10'sd256);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(3);
    do_tick();
    chk("midrst_r", sound_r, 18'sd0);
    chk("midrst_l", sound_l, 18'sd0);

    // After release only fresh samples count
    clear_in();
    wavetable_l = -10'sd512; wavetable_l_valid = 1'b1;
    volume_adsr = FULL; velocity = FULL;
    @(negedge clk);
    idle(3);
    do_tick();
    chk("post_rst_r", sound_r, 18'sd0);
    chk("post_rst_l", sound_l, -18'sd131070);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soundgen.md
SOUNDGEN -- requirements
Module: soundgen

Interface
REQ-001 Parameter: ACC_W, default 24, signed accumulator width in bits; legal range 19..32.
REQ-002 The block SHALL have exactly one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: wavetable_r  input  10  signed two's-complement voice sample for the right mix.
REQ-006 Port: wavetable_r_valid  input  1  single-cycle strobe; wavetable_r, volume_adsr and velocity are captured together.
REQ-007 Port: wavetable_l  input  10  signed voice sample for the left mix.
REQ-008 Port: wavetable_l_valid  input  1  single-cycle strobe; wavetable_l, volume_adsr and velocity are captured together.
REQ-009 Port: sound  input  16  signed auxiliary sample, mixed into both channels.
REQ-010 Port: sound_valid  input  1  strobe that captures sound.
REQ-011 Port: volume_adsr  input  18  envelope gain; bits [16:0] are an unsigned fraction (0x1FFFF ≈ 1.0); bit 17 is ignored.
REQ-012 Port: velocity  input  18  note gain; same format as volume_adsr.
REQ-013 Port: tick48k  input  1  single-cycle frame strobe at the 48 kHz output rate.
REQ-014 Port: sound_r  output  18  signed right-channel frame sample; registered.
REQ-015 Port: sound_l  output  18  signed left-channel frame sample; registered.

Function
REQ-016 Stage 1 (the valid cycle) SHALL register gain = (volume_adsr[16:0] * velocity[16:0]) >> 17, 17-bit unsigned, plus the sample and a per-channel valid bit.
REQ-017 Stage 2 SHALL register contribution = (sample sign-extended * gain) >>> 9, 18-bit signed, using arithmetic truncation toward minus infinity.
REQ-018 Stage 3 SHALL add the contribution into the channel accumulator (acc_r or acc_l, ACC_W-bit signed); an invalid stage adds 0.
REQ-019 Latency: a sample strobed in cycle N SHALL be part of the accumulator at the edge ending cycle N+2.
REQ-020 Right and left paths SHALL be independent; simultaneous r and l valids SHALL both be processed, each using the same cycle's gain.
REQ-021 Back-to-back valids on every cycle SHALL be accepted with no stall and no loss.
REQ-022 Aux path: sound SHALL be sign-extended and shifted left by 2 to 18-bit scale, delayed to the same 3-stage latency, and added to both acc_r and acc_l.
REQ-023 If a voice and an aux contribution reach stage 3 together, both SHALL be added in the same cycle.
REQ-024 On a tick48k cycle: sound_r <= sat18(acc_r), sound_l <= sat18(acc_l); each accumulator <= only that cycle's stage-3 additions (they start the new frame).
REQ-025 sat18 SHALL clamp to the range +131071 .. -131072.
REQ-026 Accumulator overflow beyond ACC_W bits SHALL be prevented by saturating the accumulator at its own limits.
REQ-027 Outputs SHALL hold their value between ticks.
REQ-028 A tick with no accumulated activity SHALL output 0.

Reset
REQ-029 While rst=0, all pipeline registers, both accumulators, sound_r and sound_l SHALL be 0 immediately, independent of clk.
REQ-030 Strobes asserted while rst=0 SHALL be discarded.
REQ-031 Reset asserted mid-frame SHALL discard in-flight contributions.
REQ-032 The first tick after reset release SHALL reflect only samples strobed after release.

Verification
REQ-033 Reset: hold rst=0 with random inputs -> sound_r = sound_l = 0; release with no strobes, then tick -> outputs 0.
REQ-034 Single voice: wavetable_r=256, vol=vel=0x1FFFF, strobe, wait 3 cycles, tick -> sound_r=65535, sound_l=0.
REQ-035 Left and negative: wavetable_l=-512 at full gain, then wavetable_l=0 -> sound_l=-131070; zero sample and zero-gain strobes (vol=0) contribute 0.
REQ-036 Saturation: two right strobes of 511 at full gain (130814 each) in one frame -> sound_r=131071; two strobes of -512 -> -131072.
REQ-037 Aux and simultaneity: sound=0x4000 with sound_valid, in the same cycle as a right strobe of 256 at full gain -> sound_r=131071 (saturated), sound_l=65536.
REQ-038 Frame boundary: strobe 2 cycles before tick -> not in this frame's output, appears at the next tick; an immediate second tick -> outputs 0.
